// File: rtl/texture_sampler_arbiter_pkg.sv
// Shared definitions for the two-requester texture sampler arbiter.
// Result record packing (MSB first): texel00, texel01, texel10, texel11, subS, subT.
package texture_sampler_arbiter_pkg;

   localparam int REQ_ID_WIDTH   = 1;
   localparam int SUBCOORD_WIDTH = 16;

   function automatic int sampler_latency(input int memory_delay);
      return memory_delay + 2;
   endfunction

   function automatic int result_width(input int pixel_width);
      return 4 * pixel_width + 2 * SUBCOORD_WIDTH;
   endfunction

endpackage

// File: rtl/texture_sampler_arbiter_fifo.sv
// Synchronous first-word-fall-through result FIFO with an occupancy count.
// Head data reads as zero while empty so an idle consumer port is quiet.
module texture_result_fifo #(
   parameter int WIDTH = 160,
   parameter int DEPTH = 4,
   localparam int CNT_W = $clog2(DEPTH + 1),
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic             aclk,
   input  logic             resetn,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] wr_data,
   output logic             rd_valid,
   input  logic             rd_ready,
   output logic [WIDTH-1:0] rd_data,
   output logic [CNT_W-1:0] count
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             do_push;
   logic             do_pop;

   function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign rd_valid = (count != '0);
   assign rd_data  = rd_valid ? mem[rd_ptr] : '0;
   assign do_pop   = rd_ready && rd_valid;
   // A write into a full FIFO is dropped; upstream credits keep this from happening.
   assign do_push  = wr_en && ((count != CNT_W'(DEPTH)) || do_pop);

   always_ff @(posedge aclk) begin
      if (do_push) mem[wr_ptr] <= wr_data;
   end

   always_ff @(posedge aclk) begin
      if (!resetn) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= next_ptr(wr_ptr);
         if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
         if (do_push && !do_pop)      count <= count + 1'b1;
         else if (do_pop && !do_push) count <= count - 1'b1;
      end
   end

endmodule

// File: rtl/texture_sampler_arbiter.sv
// Round-robin arbiter sharing one fixed-latency texture sampler between TMU0 and TMU1,
// with a tag shadow pipeline steering results into per-requester credit-managed FIFOs.
module texture_sampler_arbiter
   import texture_sampler_arbiter_pkg::*;
#(
   parameter int MEMORY_DELAY = 1,
   parameter int PIXEL_WIDTH  = 32,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic                   aclk,
   input  logic                   resetn,
   input  logic                   s0_valid,
   output logic                   s0_ready,
   input  logic [15:0]            s0_texelS,
   input  logic [15:0]            s0_texelT,
   input  logic                   s0_clampS,
   input  logic                   s0_clampT,
   input  logic [7:0]             s0_sizeW,
   input  logic [7:0]             s0_sizeH,
   input  logic                   s1_valid,
   output logic                   s1_ready,
   input  logic [15:0]            s1_texelS,
   input  logic [15:0]            s1_texelT,
   input  logic                   s1_clampS,
   input  logic                   s1_clampT,
   input  logic [7:0]             s1_sizeW,
   input  logic [7:0]             s1_sizeH,
   output logic                   m0_valid,
   input  logic                   m0_ready,
   output logic [PIXEL_WIDTH-1:0] m0_texel00,
   output logic [PIXEL_WIDTH-1:0] m0_texel01,
   output logic [PIXEL_WIDTH-1:0] m0_texel10,
   output logic [PIXEL_WIDTH-1:0] m0_texel11,
   output logic [15:0]            m0_subCoordS,
   output logic [15:0]            m0_subCoordT,
   output logic                   m1_valid,
   input  logic                   m1_ready,
   output logic [PIXEL_WIDTH-1:0] m1_texel00,
   output logic [PIXEL_WIDTH-1:0] m1_texel01,
   output logic [PIXEL_WIDTH-1:0] m1_texel10,
   output logic [PIXEL_WIDTH-1:0] m1_texel11,
   output logic [15:0]            m1_subCoordS,
   output logic [15:0]            m1_subCoordT,
   output logic [15:0]            smp_texelS,
   output logic [15:0]            smp_texelT,
   output logic                   smp_clampS,
   output logic                   smp_clampT,
   output logic [7:0]             smp_sizeW,
   output logic [7:0]             smp_sizeH,
   input  logic [PIXEL_WIDTH-1:0] smp_texel00,
   input  logic [PIXEL_WIDTH-1:0] smp_texel01,
   input  logic [PIXEL_WIDTH-1:0] smp_texel10,
   input  logic [PIXEL_WIDTH-1:0] smp_texel11,
   input  logic [15:0]            smp_subCoordS,
   input  logic [15:0]            smp_subCoordT
);

   localparam int L     = sampler_latency(MEMORY_DELAY);
   localparam int RW    = result_width(PIXEL_WIDTH);
   localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

   logic [CNT_W-1:0]        count0, count1;
   logic [CNT_W-1:0]        inflight0, inflight1;
   logic                    elig0, elig1, grant0, grant1, issue;
   logic [REQ_ID_WIDTH-1:0] grant_id;
   logic                    last_grant;
   logic [L-1:0]            tag_valid;
   logic [REQ_ID_WIDTH-1:0] tag_id [L];
   logic                    wr0, wr1;
   logic [RW-1:0]           smp_result, m0_data, m1_data;

   // Credit is free space not yet claimed by queued or in-flight results.
   assign elig0 = s0_valid && (({1'b0, count0} + {1'b0, inflight0}) < (CNT_W+1)'(FIFO_DEPTH));
   assign elig1 = s1_valid && (({1'b0, count1} + {1'b0, inflight1}) < (CNT_W+1)'(FIFO_DEPTH));

   assign grant0   = elig0 && (!elig1 || last_grant);
   assign grant1   = elig1 && (!elig0 || !last_grant);
   assign issue    = grant0 || grant1;
   assign grant_id = REQ_ID_WIDTH'(grant1);
   assign s0_ready = grant0;
   assign s1_ready = grant1;

   assign smp_texelS = grant1 ? s1_texelS : s0_texelS;
   assign smp_texelT = grant1 ? s1_texelT : s0_texelT;
   assign smp_clampS = grant1 ? s1_clampS : s0_clampS;
   assign smp_clampT = grant1 ? s1_clampT : s0_clampT;
   assign smp_sizeW  = grant1 ? s1_sizeW  : s0_sizeW;
   assign smp_sizeH  = grant1 ? s1_sizeH  : s0_sizeH;

   always_ff @(posedge aclk) begin
      if (!resetn) begin
         last_grant <= 1'b1;
         tag_valid  <= '0;
         for (int i = 0; i < L; i++) tag_id[i] <= '0;
      end else begin
         if (issue) last_grant <= grant1;
         tag_valid <= {tag_valid[L-2:0], issue};
         tag_id[0] <= grant_id;
         for (int i = 1; i < L; i++) tag_id[i] <= tag_id[i-1];
      end
   end

   // Results are captured in the cycle their tag reaches the last stage.
   assign wr0 = tag_valid[L-1] && (tag_id[L-1] == '0);
   assign wr1 = tag_valid[L-1] && (tag_id[L-1] != '0);

   always_ff @(posedge aclk) begin
      if (!resetn) begin
         inflight0 <= '0;
         inflight1 <= '0;
      end else begin
         if (grant0 && !wr0)      inflight0 <= inflight0 + 1'b1;
         else if (wr0 && !grant0) inflight0 <= inflight0 - 1'b1;
         if (grant1 && !wr1)      inflight1 <= inflight1 + 1'b1;
         else if (wr1 && !grant1) inflight1 <= inflight1 - 1'b1;
      end
   end

   assign smp_result = {smp_texel00, smp_texel01, smp_texel10, smp_texel11,
                        smp_subCoordS, smp_subCoordT};

   texture_result_fifo #(.WIDTH(RW), .DEPTH(FIFO_DEPTH)) u_fifo0 (
      .aclk(aclk), .resetn(resetn), .wr_en(wr0), .wr_data(smp_result),
      .rd_valid(m0_valid), .rd_ready(m0_ready), .rd_data(m0_data), .count(count0)
   );

   texture_result_fifo #(.WIDTH(RW), .DEPTH(FIFO_DEPTH)) u_fifo1 (
      .aclk(aclk), .resetn(resetn), .wr_en(wr1), .wr_data(smp_result),
      .rd_valid(m1_valid), .rd_ready(m1_ready), .rd_data(m1_data), .count(count1)
   );

   assign {m0_texel00, m0_texel01, m0_texel10, m0_texel11, m0_subCoordS, m0_subCoordT} = m0_data;
   assign {m1_texel00, m1_texel01, m1_texel10, m1_texel11, m1_subCoordS, m1_subCoordT} = m1_data;

endmodule

// File: tb/tb_texture_sampler_arbiter.sv
// Randomized scoreboard bench for texture_sampler_arbiter with a fixed-latency sampler model.
module tb_texture_sampler_arbiter;

   localparam int MEMORY_DELAY = 1;
   localparam int PW           = 32;
   localparam int DEPTH        = 4;
   localparam int L            = MEMORY_DELAY + 2;
   localparam int RW           = 4 * PW + 32;

   logic          aclk = 1'b0;
   logic          resetn;
   logic          s0_valid, s1_valid, s0_ready, s1_ready;
   logic [15:0]   s0_texelS, s0_texelT, s1_texelS, s1_texelT;
   logic          s0_clampS, s0_clampT, s1_clampS, s1_clampT;
   logic [7:0]    s0_sizeW, s0_sizeH, s1_sizeW, s1_sizeH;
   logic          m0_valid, m0_ready, m1_valid, m1_ready;
   logic [PW-1:0] m0_texel00, m0_texel01, m0_texel10, m0_texel11;
   logic [PW-1:0] m1_texel00, m1_texel01, m1_texel10, m1_texel11;
   logic [15:0]   m0_subCoordS, m0_subCoordT, m1_subCoordS, m1_subCoordT;
   logic [15:0]   smp_texelS, smp_texelT;
   logic          smp_clampS, smp_clampT;
   logic [7:0]    smp_sizeW, smp_sizeH;
   logic [PW-1:0] smp_texel00, smp_texel01, smp_texel10, smp_texel11;
   logic [15:0]   smp_subCoordS, smp_subCoordT;

   always #5 aclk = ~aclk;

   texture_sampler_arbiter #(.MEMORY_DELAY(MEMORY_DELAY), .PIXEL_WIDTH(PW), .FIFO_DEPTH(DEPTH)) dut (
      .aclk(aclk), .resetn(resetn),
      .s0_valid(s0_valid), .s0_ready(s0_ready), .s0_texelS(s0_texelS), .s0_texelT(s0_texelT),
      .s0_clampS(s0_clampS), .s0_clampT(s0_clampT), .s0_sizeW(s0_sizeW), .s0_sizeH(s0_sizeH),
      .s1_valid(s1_valid), .s1_ready(s1_ready), .s1_texelS(s1_texelS), .s1_texelT(s1_texelT),
      .s1_clampS(s1_clampS), .s1_clampT(s1_clampT), .s1_sizeW(s1_sizeW), .s1_sizeH(s1_sizeH),
      .m0_valid(m0_valid), .m0_ready(m0_ready), .m0_texel00(m0_texel00), .m0_texel01(m0_texel01),
      .m0_texel10(m0_texel10), .m0_texel11(m0_texel11), .m0_subCoordS(m0_subCoordS), .m0_subCoordT(m0_subCoordT),
      .m1_valid(m1_valid), .m1_ready(m1_ready), .m1_texel00(m1_texel00), .m1_texel01(m1_texel01),
      .m1_texel10(m1_texel10), .m1_texel11(m1_texel11), .m1_subCoordS(m1_subCoordS), .m1_subCoordT(m1_subCoordT),
      .smp_texelS(smp_texelS), .smp_texelT(smp_texelT), .smp_clampS(smp_clampS), .smp_clampT(smp_clampT),
      .smp_sizeW(smp_sizeW), .smp_sizeH(smp_sizeH),
      .smp_texel00(smp_texel00), .smp_texel01(smp_texel01), .smp_texel10(smp_texel10), .smp_texel11(smp_texel11),
      .smp_subCoordS(smp_subCoordS), .smp_subCoordT(smp_subCoordT)
   );

   // ---------------- sampler model: pure function of the request, L cycles later
   function automatic logic [RW-1:0] samp(input logic [49:0] r);
      logic [15:0] s, t;
      logic        cs, ct;
      logic [7:0]  w, h;
      {s, t, cs, ct, w, h} = r;
      return {({s, t} ^ 32'hAABBCCDD), ({t, s} + 32'h0001_3579), {w, h, s},
              ({cs, ct, 14'h0, t} ^ {w, h, 16'h0}), (s ^ 16'h5A5A), (t + {w, h})};
   endfunction

   logic [49:0] pipe [L];
   always @(posedge aclk) begin
      pipe[0] <= {smp_texelS, smp_texelT, smp_clampS, smp_clampT, smp_sizeW, smp_sizeH};
      for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
   end
   assign {smp_texel00, smp_texel01, smp_texel10, smp_texel11, smp_subCoordS, smp_subCoordT} = samp(pipe[L-1]);

   // ---------------- scoreboard
   int n_checks = 0;
   int n_fail   = 0;
   logic [RW-1:0] exp_q0[$], exp_q1[$];
   int            arr_q0[$], arr_q1[$];
   int            out0, out1;
   int            cyc = 0;
   bit            last_model = 1'b1;
   bit            just_rst = 1'b0;

   task automatic check(input string nm, input logic [RW-1:0] act, input logic [RW-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s @cyc %0d: got %h expected %h", nm, cyc, act, exp);
      end
   endtask

   always @(negedge aclk) begin
      bit e0, e1, g0, g1, v0, v1;
      cyc++;
      if (!resetn) begin
         exp_q0.delete(); exp_q1.delete(); arr_q0.delete(); arr_q1.delete();
         out0 = 0; out1 = 0; last_model = 1'b1; just_rst = 1'b1;
      end else begin
         if (just_rst) begin
            check("m0_data_after_reset",
                  {m0_texel00, m0_texel01, m0_texel10, m0_texel11, m0_subCoordS, m0_subCoordT}, '0);
            check("m1_data_after_reset",
                  {m1_texel00, m1_texel01, m1_texel10, m1_texel11, m1_subCoordS, m1_subCoordT}, '0);
            just_rst = 1'b0;
         end
         e0 = s0_valid && (out0 < DEPTH);
         e1 = s1_valid && (out1 < DEPTH);
         g0 = e0 && (!e1 || last_model);
         g1 = e1 && (!e0 || !last_model);
         v0 = (exp_q0.size() > 0) && (arr_q0[0] <= cyc);
         v1 = (exp_q1.size() > 0) && (arr_q1[0] <= cyc);
         check("s0_ready", RW'(s0_ready), RW'(g0));
         check("s1_ready", RW'(s1_ready), RW'(g1));
         check("m0_valid", RW'(m0_valid), RW'(v0));
         check("m1_valid", RW'(m1_valid), RW'(v1));
         if (v0 && m0_ready) begin
            check("m0_data", {m0_texel00, m0_texel01, m0_texel10, m0_texel11, m0_subCoordS, m0_subCoordT},
                  exp_q0[0]);
            void'(exp_q0.pop_front()); void'(arr_q0.pop_front()); out0--;
         end
         if (v1 && m1_ready) begin
            check("m1_data", {m1_texel00, m1_texel01, m1_texel10, m1_texel11, m1_subCoordS, m1_subCoordT},
                  exp_q1[0]);
            void'(exp_q1.pop_front()); void'(arr_q1.pop_front()); out1--;
         end
         if (g0) begin
            exp_q0.push_back(samp({s0_texelS, s0_texelT, s0_clampS, s0_clampT, s0_sizeW, s0_sizeH}));
            arr_q0.push_back(cyc + L + 1); out0++; last_model = 1'b0;
         end
         if (g1) begin
            exp_q1.push_back(samp({s1_texelS, s1_texelT, s1_clampS, s1_clampT, s1_sizeW, s1_sizeH}));
            arr_q1.push_back(cyc + L + 1); out1++; last_model = 1'b1;
         end
      end
   end

   // ---------------- driver tasks
   task automatic rand_fields();
      s0_texelS = 16'($urandom); s0_texelT = 16'($urandom);
      s0_clampS = 1'($urandom);  s0_clampT = 1'($urandom);
      s0_sizeW  = 8'(1 << $urandom_range(0, 7)); s0_sizeH = 8'(1 << $urandom_range(0, 7));
      s1_texelS = 16'($urandom); s1_texelT = 16'($urandom);
      s1_clampS = 1'($urandom);  s1_clampT = 1'($urandom);
      s1_sizeW  = 8'(1 << $urandom_range(0, 7)); s1_sizeH = 8'(1 << $urandom_range(0, 7));
   endtask

   task automatic cycle(input logic v0, input logic v1, input logic r0, input logic r1);
      @(posedge aclk); #1;
      resetn = 1'b1;
      s0_valid = v0; s1_valid = v1; m0_ready = r0; m1_ready = r1;
      rand_fields();
   endtask

   task automatic reset_cycle();
      @(posedge aclk); #1;
      resetn = 1'b0;
   endtask

   initial begin
      resetn = 1'b0;
      s0_valid = 0; s1_valid = 0; m0_ready = 0; m1_ready = 0;
      rand_fields();
      repeat (3) @(posedge aclk);
      // single request on TMU0 with a specific coordinate pair
      cycle(1, 0, 1, 1);
      s0_texelS = 16'h4000; s0_texelT = 16'h2000; s0_sizeW = 8'h04; s0_sizeH = 8'h04;
      repeat (8) cycle(0, 0, 1, 1);
      // tie: both requesters held valid
      repeat (6) cycle(1, 1, 1, 1);
      repeat (8) cycle(0, 0, 1, 1);
      // back-pressure on TMU0, single pop, then more back-pressure
      repeat (10) cycle(1, 0, 0, 1);
      cycle(1, 0, 1, 1);
      repeat (6) cycle(1, 0, 0, 1);
      repeat (10) cycle(0, 0, 1, 1);
      // random traffic
      repeat (400) cycle($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                         $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);
      // reset with requests in flight, then a tie
      repeat (3) cycle(1, 1, 0, 0);
      reset_cycle();
      repeat (6) cycle(0, 0, 1, 1);
      repeat (4) cycle(1, 1, 1, 1);
      repeat (8) cycle(0, 0, 1, 1);
      // streaming on TMU1 alone
      repeat (120) cycle(0, 1, 1, 1);
      repeat (20) cycle(0, 0, 1, 1);
      @(negedge aclk);
      check("drain0_empty", RW'(exp_q0.size()), '0);
      check("drain1_empty", RW'(exp_q1.size()), '0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
